// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush and
// data-memory wait/timeout freeze for a 5-stage in-order pipeline.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_nop,
  input  logic             id_j,
  input  logic             ex_lw,
  input  logic [4:0]       ex_rt,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             err_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             tmo_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO + 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_TMO = WCNT_W'(MEM_TMO);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              tmo_nxt;
  logic              mem_stall;
  logic              freeze;
  logic              load_use;
  logic              stall_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic lu_hit(
    input logic       lw,
    input logic [4:0] dst,
    input logic       nop,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return lw && (dst != 5'd0) && !nop &&
           ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

  assign mem_stall = mem_req && !mem_ready;
  assign freeze    = (cur_state != RUN) || mem_stall;
  assign load_use  = lu_hit(ex_lw, ex_rt, id_nop, id_rs, id_rt, id_uses_rt);
  // A taken branch squashes the dependent instruction, so no stall is counted.
  assign stall_evt = freeze || (load_use && !ex_br_taken);
  assign state     = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= RUN;
      wcnt      <= '0;
      tmo_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      wcnt      <= wcnt_nxt;
      tmo_err   <= tmo_nxt;
      if (stall_evt)  stall_cnt <= sat_inc(stall_cnt);
      if (ifid_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  always_comb begin
    nxt_state = cur_state;
    wcnt_nxt  = wcnt;
    tmo_nxt   = tmo_err;
    unique case (cur_state)
      RUN: begin
        if (mem_stall) begin
          nxt_state = MEMWAIT;
          wcnt_nxt  = WCNT_ONE;
        end
      end
      MEMWAIT: begin
        if (mem_ready) begin
          nxt_state = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNT_TMO) begin
          nxt_state = ERR;
          tmo_nxt   = 1'b1;
        end else begin
          wcnt_nxt  = wcnt + WCNT_ONE;
        end
      end
      ERR: begin
        if (err_clr) begin
          nxt_state = RUN;
          wcnt_nxt  = '0;
          tmo_nxt   = 1'b0;
        end
      end
      default: begin
        nxt_state = RUN;
        wcnt_nxt  = '0;
        tmo_nxt   = 1'b0;
      end
    endcase
  end

  // Freeze holds every stage, including a pending taken branch in EX.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!freeze) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_j) begin
        ifid_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 16;
  localparam int CNT_S = 2;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, id_nop, id_j, ex_lw, ex_br_taken;
  logic             mem_req, mem_ready, err_clr;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, tmo_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic             s_ifid_flush, s_idex_flush, s_tmo_err;
  logic [1:0]       s_state;
  logic [CNT_S-1:0] s_stall_cnt, s_flush_cnt;
  logic [6:0]       dut_out, s_out;

  int checks;
  int failures;

  int m_state, m_wait, m_stall, m_flush, m_stall_s, m_flush_s;
  bit m_tmo;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_nop(id_nop), .id_j(id_j), .ex_lw(ex_lw),
    .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .err_clr(err_clr), .pc_en(pc_en),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .tmo_err(tmo_err), .state(state), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(CNT_S), .MEM_TMO(TMO)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_nop(id_nop), .id_j(id_j), .ex_lw(ex_lw),
    .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .err_clr(err_clr), .pc_en(s_pc_en),
    .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .tmo_err(s_tmo_err), .state(s_state),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  assign dut_out = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
  assign s_out   = {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
                    s_ifid_flush, s_idex_flush};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit model_lu();
    return ex_lw && ex_rt != 0 && !id_nop &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic bit model_frozen();
    return m_state != 0 || (mem_req && !mem_ready);
  endfunction

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  function automatic logic [6:0] model_out();
    if (model_frozen())  return 7'b00000_00;
    if (ex_br_taken)     return 7'b11111_11;
    if (model_lu())      return 7'b00111_01;
    if (id_j)            return 7'b11111_10;
    return 7'b11111_00;
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_tmo = 0;
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
  endtask

  task automatic model_step();
    logic [6:0] o;
    bit stall;
    o = model_out();
    stall = model_frozen() || (model_lu() && !ex_br_taken);
    if (stall) begin
      m_stall   = (m_stall   < (1 << CNT_W) - 1) ? m_stall + 1   : m_stall;
      m_stall_s = (m_stall_s < (1 << CNT_S) - 1) ? m_stall_s + 1 : m_stall_s;
    end
    if (o[1]) begin
      m_flush   = (m_flush   < (1 << CNT_W) - 1) ? m_flush + 1   : m_flush;
      m_flush_s = (m_flush_s < (1 << CNT_S) - 1) ? m_flush_s + 1 : m_flush_s;
    end
    // m_wait counts cycles spent in MEMWAIT so far
    if (m_state == 0) begin
      if (mem_req && !mem_ready) begin m_state = 1; m_wait = 1; end
    end else if (m_state == 1) begin
      if (mem_ready)            begin m_state = 0; m_wait = 0; end
      else if (m_wait >= TMO)   begin m_state = 2; m_tmo = 1; end
      else                      m_wait++;
    end else begin
      if (err_clr) begin m_state = 0; m_tmo = 0; m_wait = 0; end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; id_nop = 0; id_j = 0;
    ex_lw = 0; ex_br_taken = 0; mem_req = 0; mem_ready = 0; err_clr = 0;
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    model_reset();
    #2;
    rst_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst_n = 0;
    ex_br_taken = 1;
    #2;
    checks++;
    if (state !== 2'd0 || tmo_err !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      failures++;
      $display("FAIL reset_regs got state=%0d tmo=%b stall=%0d flush=%0d exp 0/0/0/0",
               state, tmo_err, stall_cnt, flush_cnt);
    end
    checks++;
    if (dut_out !== 7'b11111_11) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", dut_out, 7'b11111_11);
    end
    @(posedge clk);
    #1;
    checks++;
    if (flush_cnt !== '0) begin
      failures++;
      $display("FAIL reset_hold_cnt got=%0d exp=0", flush_cnt);
    end
    rst_n = 1;
    idle();
    model_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_lw = 1; ex_rt = 5; id_rs = 5;
    @(negedge clk);
    checks++;
    if (dut_out !== 7'b00111_01 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL load_use_stall got=%b cnt=%0d exp=%b cnt=0", dut_out, stall_cnt, 7'b00111_01);
    end
    finish_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (dut_out !== 7'b11111_00 || stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_release got=%b cnt=%0d exp=%b cnt=1", dut_out, stall_cnt, 7'b11111_00);
    end
    finish_cycle();
  endtask

  task automatic test_exclusion();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      ex_lw = 1;
      case (k)
        0: begin ex_rt = 0; id_rs = 0; end
        1: begin ex_rt = 7; id_rt = 7; id_rs = 2; id_uses_rt = 0; end
        default: begin ex_rt = 9; id_rs = 9; id_nop = 1; end
      endcase
      @(negedge clk);
      checks++;
      if (dut_out !== 7'b11111_00) begin
        failures++;
        $display("FAIL exclusion_%0d got=%b exp=%b", k, dut_out, 7'b11111_00);
      end
      finish_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL exclusion_cnt got=%0d exp=0", stall_cnt);
    end
    finish_cycle();
  endtask

  task automatic test_branch_jump();
    do_reset();
    ex_lw = 1; ex_rt = 3; id_rs = 3; ex_br_taken = 1;
    @(negedge clk);
    checks++;
    if (dut_out !== 7'b11111_11) begin
      failures++;
      $display("FAIL branch_vs_lu got=%b exp=%b", dut_out, 7'b11111_11);
    end
    finish_cycle();
    idle();
    ex_lw = 1; ex_rt = 9; id_rt = 9; id_uses_rt = 1; id_j = 1;
    @(negedge clk);
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL branch_cnt got flush=%0d stall=%0d exp flush=1 stall=0", flush_cnt, stall_cnt);
    end
    checks++;
    if (dut_out !== 7'b00111_01) begin
      failures++;
      $display("FAIL jump_lu_stall got=%b exp=%b", dut_out, 7'b00111_01);
    end
    finish_cycle();
    ex_lw = 0;
    @(negedge clk);
    checks++;
    if (dut_out !== 7'b11111_10 || stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL jump_after got=%b stall=%0d exp=%b stall=1", dut_out, stall_cnt, 7'b11111_10);
    end
    finish_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (flush_cnt !== 16'd2) begin
      failures++;
      $display("FAIL jump_flush_cnt got=%0d exp=2", flush_cnt);
    end
    finish_cycle();
  endtask

  task automatic test_memwait();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      mem_req = 1;
      mem_ready = (k == 3);
      ex_br_taken = (k == 1);
      @(negedge clk);
      checks++;
      if (dut_out !== 7'b0 || state !== ((k == 0) ? 2'd0 : 2'd1)) begin
        failures++;
        $display("FAIL memwait_%0d got out=%b state=%0d exp out=0 state=%0d",
                 k, dut_out, state, (k == 0) ? 0 : 1);
      end
      finish_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || stall_cnt !== 16'd4 || flush_cnt !== 16'd0 || dut_out !== 7'b11111_00) begin
      failures++;
      $display("FAIL memwait_done got state=%0d stall=%0d flush=%0d out=%b exp 0/4/0/1111100",
               state, stall_cnt, flush_cnt, dut_out);
    end
    finish_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (dut_out !== 7'b0 || tmo_err !== 1'b0 || state !== ((k == 0) ? 2'd0 : 2'd1)) begin
        failures++;
        $display("FAIL tmo_wait_%0d got out=%b tmo=%b state=%0d", k, dut_out, tmo_err, state);
      end
      finish_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || tmo_err !== 1'b1 || dut_out !== 7'b0) begin
      failures++;
      $display("FAIL tmo_err_set got state=%0d tmo=%b out=%b exp 2/1/0", state, tmo_err, dut_out);
    end
    finish_cycle();
    err_clr = 1;
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || tmo_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_err_hold got state=%0d tmo=%b exp 2/1", state, tmo_err);
    end
    finish_cycle();
    err_clr = 0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || tmo_err !== 1'b0 || dut_out !== 7'b11111_00 || stall_cnt !== 16'd7) begin
      failures++;
      $display("FAIL tmo_clear got state=%0d tmo=%b out=%b stall=%0d exp 0/0/1111100/7",
               state, tmo_err, dut_out, stall_cnt);
    end
    finish_cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int k = 0; k < 3; k++) finish_cycle();
    checks++;
    if (state !== 2'd1 || stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL areset_pre got state=%0d stall=%0d exp 1/3", state, stall_cnt);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== '0 || flush_cnt !== '0 || tmo_err !== 1'b0) begin
      failures++;
      $display("FAIL areset_memwait got state=%0d stall=%0d flush=%0d tmo=%b exp 0",
               state, stall_cnt, flush_cnt, tmo_err);
    end
    #1 rst_n = 1;
    model_reset();
    for (int k = 0; k < 6; k++) finish_cycle();
    checks++;
    if (state !== 2'd2 || tmo_err !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre_err got state=%0d tmo=%b exp 2/1", state, tmo_err);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (state !== 2'd0 || tmo_err !== 1'b0 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL areset_err got state=%0d tmo=%b stall=%0d exp 0/0/0", state, tmo_err, stall_cnt);
    end
    #1 rst_n = 1;
    model_reset();
    idle();
    ex_lw = 1; ex_rt = 12; id_rs = 12;
    for (int k = 0; k < 5; k++) finish_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (s_stall_cnt !== 2'd3 || stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL saturation got narrow=%0d wide=%0d exp narrow=3 wide=5", s_stall_cnt, stall_cnt);
    end
    finish_cycle();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    bit slow;
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      slow = ((i / 150) % 2) == 1;
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = ($urandom_range(0, 1) == 1);
      id_nop      = ($urandom_range(0, 9) == 0);
      id_j        = ($urandom_range(0, 6) == 0);
      ex_lw       = ($urandom_range(0, 1) == 1);
      ex_br_taken = ($urandom_range(0, 6) == 0);
      mem_req     = ($urandom_range(0, 2) == 0);
      mem_ready   = slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
      err_clr     = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      exp = model_out();
      checks++;
      if (dut_out !== exp || s_out !== exp) begin
        failures++;
        $display("FAIL rnd_out cyc=%0d got=%b narrow=%b exp=%b", i, dut_out, s_out, exp);
      end
      checks++;
      if (state !== 2'(m_state) || s_state !== 2'(m_state) ||
          tmo_err !== m_tmo || s_tmo_err !== m_tmo) begin
        failures++;
        $display("FAIL rnd_fsm cyc=%0d got state=%0d/%0d tmo=%b/%b exp state=%0d tmo=%b",
                 i, state, s_state, tmo_err, s_tmo_err, m_state, m_tmo);
      end
      checks++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush) ||
          s_stall_cnt !== CNT_S'(m_stall_s) || s_flush_cnt !== CNT_S'(m_flush_s)) begin
        failures++;
        $display("FAIL rnd_cnt cyc=%0d got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", i,
                 stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt,
                 m_stall, m_flush, m_stall_s, m_flush_s);
      end
      finish_cycle();
    end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    model_reset();
    rst_n = 0;
    test_reset();
    test_load_use();
    test_exclusion();
    test_branch_jump();
    test_memwait();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
